// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver.
//   - rx_state_e  : receiver state enumeration
//   - *_DEF       : default frame geometry and system clock rate
//   - tick_w()    : width of the oversampling tick counter
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int CLK_RATE       = 50_000_000;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Tick counter must hold 0..os-1; keep at least one bit for degenerate os.
    function automatic int tick_w(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
// Both flops reset to 1 (line idle) so reset never looks like a start bit.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   rx   in   raw serial line (asynchronous)
//   rxS  out  rx synchronized to clk
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxS
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            rxS  <= 1'b1;
        end else begin
            meta <= rx;
            rxS  <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART deframer (8N1, or 8E1 when the
// UART_RX_PARITY_EN macro is defined).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   baudTick   in   one-clk pulse, OVERSAMPLE per bit period
//   rx         in   serial line, idle high, asynchronous
//   dataOut    out  last good byte, held until the next good frame
//   rxDone     out  one-clk pulse when dataOut updates
//   frameErr   out  one-clk pulse when the stop bit is sampled low
//   parityErr  out  one-clk pulse on even-parity mismatch (0 without macro)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baudTick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rxDone,
    output logic                  frameErr,
    output logic                  parityErr
);

    localparam int TW = tick_w(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] END_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e             state;
    logic [TW-1:0]         tickCnt;
    logic [BW-1:0]         bitCnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rxS;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .rxS (rxS)
    );

`ifdef UART_RX_PARITY_EN
    logic parBad;   // parity mismatch latched in PARITY, acted on in STOP
`else
    assign parityErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shreg    <= '0;
            dataOut  <= '0;
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBad    <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxS) begin
                        state   <= START;
                        tickCnt <= '0;
                    end
                end

                // Re-check the line mid start bit; a short low pulse is a glitch.
                START: begin
                    if (baudTick) begin
                        if (tickCnt == MID_TICK) begin
                            tickCnt <= '0;
                            bitCnt  <= '0;
                            state   <= rxS ? IDLE : DATA;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end

                // tickCnt free-runs and wraps, so each sample lands one full
                // bit after the previous one, i.e. mid bit.
                DATA: begin
                    if (baudTick) begin
                        tickCnt <= tickCnt + 1'b1;
                        if (tickCnt == END_TICK) begin
                            shreg  <= {rxS, shreg[DATA_WIDTH-1:1]};
                            bitCnt <= bitCnt + 1'b1;
                            if (bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baudTick) begin
                        tickCnt <= tickCnt + 1'b1;
                        if (tickCnt == END_TICK) begin
                            parBad <= rxS ^ (^shreg);
                            state  <= STOP;
                        end
                    end
                end
`endif

                // Decide mid stop bit and re-arm at once so back-to-back
                // frames with a single stop bit are caught.
                STOP: begin
                    if (baudTick) begin
                        tickCnt <= tickCnt + 1'b1;
                        if (tickCnt == END_TICK) begin
                            state <= IDLE;
                            if (!rxS) begin
                                frameErr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (parBad) begin
                                parityErr <= 1'b1;
`endif
                            end else begin
                                dataOut <= shreg;
                                rxDone  <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized self-checking bench for uart_receiver.
// Frames are driven bit by bit on baudTick boundaries; a frame-level model
// (good byte / stop error / parity error) predicts pulses and dataOut.
// Build with UART_RX_PARITY_EN defined to cover the 8E1 variant.
module tb_uart_receiver;

    localparam int DW = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_TICKS = (DW + 2 + int'(PAR)) * OS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baudTick = 1'b0;
    logic          rx = 1'b1;
    logic [DW-1:0] dataOut;
    logic          rxDone, frameErr, parityErr;

    uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baudTick  (baudTick),
        .rx        (rx),
        .dataOut   (dataOut),
        .rxDone    (rxDone),
        .frameErr  (frameErr),
        .parityErr (parityErr)
    );

    always #10 clk = ~clk;   // 50 MHz

    // Baud generator: one tick every div clocks (163 = 19200 baud x16 at 50 MHz).
    int div = 163;
    int divCnt = 0;
    always @(posedge clk) begin
        if (divCnt >= div - 1) begin
            divCnt   <= 0;
            baudTick <= 1'b1;
        end else begin
            divCnt   <= divCnt + 1;
            baudTick <= 1'b0;
        end
    end

    // Output monitor: pulse counts, pulse widths, overlap, tick stamps.
    int            nDone = 0, nFerr = 0, nPerr = 0, nWide = 0, nBoth = 0;
    longint        tickTotal = 0;
    longint        doneTick[$];
    logic [DW-1:0] doneVal[$];
    logic          prevDone = 1'b0, prevFerr = 1'b0, prevPerr = 1'b0;
    always @(negedge clk) begin
        if (baudTick) tickTotal++;
        if (rxDone) begin
            nDone++;
            doneTick.push_back(tickTotal);
            doneVal.push_back(dataOut);
        end
        if (frameErr)  nFerr++;
        if (parityErr) nPerr++;
        if ((rxDone && prevDone) || (frameErr && prevFerr) || (parityErr && prevPerr)) nWide++;
        if (rxDone && frameErr) nBoth++;
        prevDone = rxDone;
        prevFerr = frameErr;
        prevPerr = parityErr;
    end

    int nCmp = 0, nErr = 0;
    logic [DW-1:0] lastGood = '0;

    task automatic chk(input string tag, input longint got, input longint exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just before the n-th following tick edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(negedge clk); while (!baudTick);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit stopBit, input bit parBit);
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            wait_ticks(OS);
        end
        if (PAR) begin
            rx = parBit;
            wait_ticks(OS);
        end
        if (stopBit) begin
            rx = 1'b1;
            wait_ticks(OS);
        end else begin
            // Low just past mid stop bit, then idle so it is not a break.
            rx = 1'b0;
            wait_ticks(OS / 2 + 1);
            rx = 1'b1;
            wait_ticks(OS / 2 - 1);
        end
        rx = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] d,
                             input bit stopBit, input bit parBit);
        int  d0, f0, p0;
        bit  parOk, good;
        d0 = nDone; f0 = nFerr; p0 = nPerr;
        parOk = !PAR || (parBit == ^d);
        good  = stopBit && parOk;
        send_frame(d, stopBit, parBit);
        wait_ticks(4);
        if (good) lastGood = d;
        chk({tag, ".done"}, nDone - d0, good);
        chk({tag, ".ferr"}, nFerr - f0, !stopBit);
        chk({tag, ".perr"}, nPerr - p0, stopBit && !parOk);
        chk({tag, ".data"}, dataOut, lastGood);
    endtask

    initial begin
        int n0, d0, f0, p0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst.data", dataOut, 0);
        chk("rst.done", rxDone, 0);
        chk("rst.ferr", frameErr, 0);
        chk("rst.perr", parityErr, 0);
        rst = 1'b0;

        // Nominal frame at the real 19200-baud tick rate
        wait_ticks(2);
        run_frame("a5", 8'hA5, 1'b1, ^8'hA5);

        // Faster ticks for the rest keep the run short; timing is in ticks.
        div = 4;
        wait_ticks(2);

        // Bad stop bit: frameErr, dataOut keeps 0xA5
        run_frame("5a_badstop", 8'h5A, 1'b0, ^8'h5A);

        // Start glitch of 4 ticks is rejected
        d0 = nDone; f0 = nFerr;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        chk("glitch.done", nDone - d0, 0);
        chk("glitch.ferr", nFerr - f0, 0);
        run_frame("3c", 8'h3C, 1'b1, ^8'h3C);

        // Reset in the middle of data bit 3 of 0xFF
        d0 = nDone; f0 = nFerr; p0 = nPerr;
        rx = 1'b0;
        wait_ticks(OS);
        rx = 1'b1;
        wait_ticks(OS * 3 + OS / 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.data", dataOut, 0);
        chk("rstmid.done", rxDone, 0);
        chk("rstmid.ferr", frameErr, 0);
        rst = 1'b0;
        lastGood = '0;
        wait_ticks(FRAME_TICKS);
        chk("rstmid.pulses", (nDone - d0) + (nFerr - f0) + (nPerr - p0), 0);
        run_frame("81", 8'h81, 1'b1, ^8'h81);

        // Back-to-back frames, single stop bit each
        n0 = doneTick.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(4);
        lastGood = 8'hFF;
        chk("b2b.count", doneTick.size() - n0, 2);
        if (doneTick.size() - n0 == 2) begin
            chk("b2b.spacing", doneTick[n0 + 1] - doneTick[n0], FRAME_TICKS);
            chk("b2b.val0", doneVal[n0], 8'h00);
            chk("b2b.val1", doneVal[n0 + 1], 8'hFF);
        end
        chk("b2b.data", dataOut, lastGood);

`ifdef UART_RX_PARITY_EN
        wait_ticks(2);
        run_frame("par_ok", 8'hA5, 1'b1, 1'b0);
        run_frame("par_bad", 8'hA5, 1'b1, 1'b1);
        run_frame("par_stopwins", 8'hC3, 1'b0, 1'b1);
`endif

        // Random frames
        for (int k = 0; k < 12; k++) begin
            logic [DW-1:0] d;
            bit            stopBit, parBit;
            d       = DW'($urandom);
            stopBit = ($urandom_range(0, 3) != 0);
            parBit  = (^d) ^ ($urandom_range(0, 3) == 0);
            wait_ticks(2);
            run_frame($sformatf("rnd%0d", k), d, stopBit, parBit);
        end

        chk("pulse.width", nWide, 0);
        chk("done_ferr.overlap", nBoth, 0);
        chk("perr.total_nopar", PAR ? 0 : nPerr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
